// File: rtl/env_length_unit.sv
// Envelope generator and length counter for one sound channel.
// Optional macro ENV_LENGTH_GATE_EN forces volume to 0 while the length counter is 0.
module env_length_unit #(
  parameter int VOL_W = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             quarter_tick,
  input  logic             half_tick,
  input  logic             len_load,
  input  logic [4:0]       len_index,
  input  logic             halt,
  input  logic             const_vol,
  input  logic [VOL_W-1:0] period,
  output logic [VOL_W-1:0] volume,
  output logic [LEN_W-1:0] len_count,
  output logic             len_active
);

  localparam logic [VOL_W-1:0] DMAX = {VOL_W{1'b1}};

  logic [LEN_W-1:0] len_q, len_d;
  logic             start_q, start_d;
  logic [VOL_W-1:0] div_q, div_d;
  logic [VOL_W-1:0] decay_q, decay_d;
  logic [VOL_W-1:0] raw_vol_s;

  function automatic logic [7:0] len_table(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   5'd31: v = 8'd30;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // Length counter: disable beats load, load beats the half-tick decrement.
  always_comb begin
    len_d = len_q;
    if (!enable) begin
      len_d = '0;
    end else if (len_load) begin
      len_d = LEN_W'(len_table(len_index));
    end else if (half_tick && !halt && (len_q != '0)) begin
      len_d = len_q - LEN_W'(1);
    end else begin
      len_d = len_q;
    end
  end

  // Envelope: a load coinciding with a quarter tick restarts immediately.
  always_comb begin
    start_d = start_q;
    div_d   = div_q;
    decay_d = decay_q;
    if (quarter_tick && (start_q || len_load)) begin
      start_d = 1'b0;
      decay_d = DMAX;
      div_d   = period;
    end else if (len_load) begin
      start_d = 1'b1;
    end else if (quarter_tick) begin
      if (div_q != '0) begin
        div_d = div_q - VOL_W'(1);
      end else begin
        div_d = period;
        if (decay_q != '0) begin
          decay_d = decay_q - VOL_W'(1);
        end else if (halt) begin
          decay_d = DMAX;
        end else begin
          decay_d = decay_q;
        end
      end
    end else begin
      start_d = start_q;
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      start_q <= 1'b0;
      div_q   <= '0;
      decay_q <= '0;
    end else begin
      len_q   <= len_d;
      start_q <= start_d;
      div_q   <= div_d;
      decay_q <= decay_d;
    end
  end

  assign raw_vol_s  = const_vol ? period : decay_q;
  assign len_count  = len_q;
  assign len_active = (len_q != '0);

`ifdef ENV_LENGTH_GATE_EN
  assign volume = (len_q == '0) ? '0 : raw_vol_s;
`else
  assign volume = raw_vol_s;
`endif

endmodule
